// File: rtl/execute_stage.sv
// execute_stage -- RV32I execute pipeline stage (decode -> memory).
//
// Selects the ALU operands, evaluates the ALU, resolves conditional branches
// and jumps, and registers every result into the execute->memory pipeline
// register. The stage has a latency of one cycle. It honours stall and
// invalidate requests from the hazard controller.
//
// Optional feature macro: EXECUTE_FORWARD_EN
//   defined   : adds fwd_mem_* / fwd_wb_* ports. Memory-stage results are
//               forwarded ahead of writeback results. x0 is never forwarded.
//   undefined : rs1/rs2_data_in are used as-is. The controller stalls on hazards.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   stall, invalidate       hold / squash the pipeline register
//   valid_in, pc_in         instruction present, instruction PC
//   rs1/rs2_data_in         register operands (rs2 is also the store data)
//   rs1/rs2_address_in      source register indices (used for forwarding)
//   imm_in, rd_address_in   sign-extended immediate, destination register
//   alu_function_in         ADD SUB SHR SHA SHL AND OR XOR (000..111)
//   alu_sel_pc_in/imm_in    ALU in1 = pc, ALU in2 = imm
//   branch_in, branch_cond_in, jump_in, jalr_in   control-transfer decode
//   load_in, store_in       memory-op flags
//   *_out                   registered execute->memory pipeline fields
module execute_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rs1_address_in,
  input  logic [4:0]  rs2_address_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rd_address_in,
  input  logic [2:0]  alu_function_in,
  input  logic        alu_sel_pc_in,
  input  logic        alu_sel_imm_in,
  input  logic        branch_in,
  input  logic [2:0]  branch_cond_in,
  input  logic        jump_in,
  input  logic        jalr_in,
  input  logic        load_in,
  input  logic        store_in,
`ifdef EXECUTE_FORWARD_EN
  input  logic        fwd_mem_valid,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_valid,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
`endif
  output logic        valid_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_address_out,
  output logic        load_out,
  output logic        store_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out
);

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_SHR = 3'b010;
  localparam logic [2:0] FN_SHA = 3'b011;
  localparam logic [2:0] FN_SHL = 3'b100;
  localparam logic [2:0] FN_AND = 3'b101;
  localparam logic [2:0] FN_OR  = 3'b110;
  localparam logic [2:0] FN_XOR = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_result;

  logic        r_valid;
  logic [31:0] r_result;
  logic [31:0] r_store_data;
  logic [4:0]  r_rd;
  logic        r_load;
  logic        r_store;
  logic        r_taken;
  logic [31:0] r_target;

`ifdef EXECUTE_FORWARD_EN
  // Operand forwarding: the memory stage is younger than writeback, so it wins.
  always_comb begin
    w_rs1 = rs1_data_in;
    w_rs2 = rs2_data_in;
    if (rs1_address_in != 5'd0 && fwd_mem_valid && fwd_mem_rd == rs1_address_in) begin
      w_rs1 = fwd_mem_data;
    end else if (rs1_address_in != 5'd0 && fwd_wb_valid && fwd_wb_rd == rs1_address_in) begin
      w_rs1 = fwd_wb_data;
    end else begin
      w_rs1 = rs1_data_in;
    end
    if (rs2_address_in != 5'd0 && fwd_mem_valid && fwd_mem_rd == rs2_address_in) begin
      w_rs2 = fwd_mem_data;
    end else if (rs2_address_in != 5'd0 && fwd_wb_valid && fwd_wb_rd == rs2_address_in) begin
      w_rs2 = fwd_wb_data;
    end else begin
      w_rs2 = rs2_data_in;
    end
  end
`else
  // Without forwarding, the register-file values are already correct (hazards stall).
  assign w_rs1 = rs1_data_in;
  assign w_rs2 = rs2_data_in;
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, rs1_address_in, rs2_address_in};
`endif

  assign w_in1   = alu_sel_pc_in  ? pc_in  : w_rs1;
  assign w_in2   = alu_sel_imm_in ? imm_in : w_rs2;
  assign w_shamt = w_in2[4:0];

  // ALU evaluation.
  always_comb begin
    w_alu = 32'h0;
    case (alu_function_in)
      FN_ADD:  w_alu = w_in1 + w_in2;
      FN_SUB:  w_alu = w_in1 - w_in2;
      FN_SHR:  w_alu = w_in1 >> w_shamt;
      FN_SHA:  w_alu = $unsigned($signed(w_in1) >>> w_shamt);
      FN_SHL:  w_alu = w_in1 << w_shamt;
      FN_AND:  w_alu = w_in1 & w_in2;
      FN_OR:   w_alu = w_in1 | w_in2;
      FN_XOR:  w_alu = w_in1 ^ w_in2;
      default: w_alu = 32'h0;
    endcase
  end

  // Branch condition. The codes 010 and 011 are not branches, so they are never taken.
  always_comb begin
    w_cond = 1'b0;
    case (branch_cond_in)
      BR_EQ:   w_cond = (w_rs1 == w_rs2);
      BR_NE:   w_cond = (w_rs1 != w_rs2);
      BR_LT:   w_cond = ($signed(w_rs1) <  $signed(w_rs2));
      BR_GE:   w_cond = ($signed(w_rs1) >= $signed(w_rs2));
      BR_LTU:  w_cond = (w_rs1 <  w_rs2);
      BR_GEU:  w_cond = (w_rs1 >= w_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = valid_in & (jump_in | (branch_in & w_cond));
  // JALR clears bit 0 of the target. Every other transfer is PC-relative.
  assign w_target = jalr_in ? ((w_rs1 + imm_in) & ~32'h1) : (pc_in + imm_in);
  // A jump writes the link address to rd, so the ALU output is unused for it.
  assign w_result = jump_in ? (pc_in + 32'd4) : w_alu;

  // Execute->memory pipeline register. Priority: reset > invalidate > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result     <= 32'h0;
      r_store_data <= 32'h0;
      r_rd         <= 5'd0;
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= RESET_VECTOR;
    end else if (invalidate) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
    end else if (stall) begin
      r_valid <= r_valid;
      r_taken <= r_taken;
      r_load  <= r_load;
      r_store <= r_store;
    end else begin
      r_valid      <= valid_in;
      r_result     <= w_result;
      r_store_data <= w_rs2;
      r_rd         <= rd_address_in;
      r_load       <= valid_in & load_in;
      r_store      <= valid_in & store_in;
      r_taken      <= w_taken;
      r_target     <= w_target;
    end
  end

  assign valid_out         = r_valid;
  assign alu_result_out    = r_result;
  assign store_data_out    = r_store_data;
  assign rd_address_out    = r_rd;
  assign load_out          = r_load;
  assign store_out         = r_store;
  assign branch_taken_out  = r_taken;
  assign branch_target_out = r_target;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam logic [31:0] RV = 32'h8000_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        invalidate = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = 32'h0, rs1_data_in = 32'h0, rs2_data_in = 32'h0, imm_in = 32'h0;
  logic [4:0]  rs1_address_in = 5'd0, rs2_address_in = 5'd0, rd_address_in = 5'd0;
  logic [2:0]  alu_function_in = 3'd0, branch_cond_in = 3'd0;
  logic        alu_sel_pc_in = 1'b0, alu_sel_imm_in = 1'b0, branch_in = 1'b0;
  logic        jump_in = 1'b0, jalr_in = 1'b0, load_in = 1'b0, store_in = 1'b0;
`ifdef EXECUTE_FORWARD_EN
  logic        fwd_mem_valid = 1'b0, fwd_wb_valid = 1'b0;
  logic [4:0]  fwd_mem_rd = 5'd0, fwd_wb_rd = 5'd0;
  logic [31:0] fwd_mem_data = 32'h0, fwd_wb_data = 32'h0;
`endif
  logic        valid_out, load_out, store_out, branch_taken_out;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  rd_address_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  execute_stage #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .invalidate(invalidate),
    .valid_in(valid_in), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .rs1_address_in(rs1_address_in),
    .rs2_address_in(rs2_address_in), .imm_in(imm_in), .rd_address_in(rd_address_in),
    .alu_function_in(alu_function_in), .alu_sel_pc_in(alu_sel_pc_in),
    .alu_sel_imm_in(alu_sel_imm_in), .branch_in(branch_in),
    .branch_cond_in(branch_cond_in), .jump_in(jump_in), .jalr_in(jalr_in),
    .load_in(load_in), .store_in(store_in),
`ifdef EXECUTE_FORWARD_EN
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
`endif
    .valid_out(valid_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .rd_address_out(rd_address_out),
    .load_out(load_out), .store_out(store_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [2:0]  fn;
    logic        sel_pc, sel_imm, br;
    logic [2:0]  cond;
    logic        jmp, jalr, ld, st;
    logic [4:0]  rd;
    logic        e_taken;
    logic [31:0] e_result, e_target;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, rs1, rs2, imm,
                              input logic [2:0] fn, input logic sp, si, br,
                              input logic [2:0] cond, input logic jmp, jalr, ld, st,
                              input logic [4:0] rd, input logic et,
                              input logic [31:0] er, input logic [31:0] etg);
    vec_t t;
    t.valid = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.fn = fn;
    t.sel_pc = sp; t.sel_imm = si; t.br = br; t.cond = cond; t.jmp = jmp;
    t.jalr = jalr; t.ld = ld; t.st = st; t.rd = rd; t.e_taken = et;
    t.e_result = er; t.e_target = etg;
    return t;
  endfunction

  // Reference model written directly from the instruction semantics.
  function automatic void model(input vec_t v, output logic [31:0] res,
                                output logic tk, output logic [31:0] tgt);
    logic [31:0] a, b, alu;
    logic [63:0] ext;
    int sh;
    logic c;
    a = v.sel_pc ? v.pc : v.rs1;
    b = v.sel_imm ? v.imm : v.rs2;
    sh = int'(b % 32'd32);
    ext = {{32{a[31]}}, a} >> sh;
    case (v.fn)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a >> sh;
      3'd3: alu = ext[31:0];
      3'd4: alu = a << sh;
      3'd5: alu = a & b;
      3'd6: alu = a | b;
      default: alu = a ^ b;
    endcase
    case (v.cond)
      3'd0: c = (v.rs1 == v.rs2);
      3'd1: c = (v.rs1 != v.rs2);
      3'd4: c = (int'(v.rs1) < int'(v.rs2));
      3'd5: c = (int'(v.rs1) >= int'(v.rs2));
      3'd6: c = (v.rs1 < v.rs2);
      3'd7: c = (v.rs1 >= v.rs2);
      default: c = 1'b0;
    endcase
    tk  = v.valid & (v.jmp | (v.br & c));
    tgt = v.jalr ? ((v.rs1 + v.imm) & ~32'h1) : (v.pc + v.imm);
    res = v.jmp ? (v.pc + 32'd4) : alu;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_in = v.valid; pc_in = v.pc; rs1_data_in = v.rs1; rs2_data_in = v.rs2;
    imm_in = v.imm; alu_function_in = v.fn; alu_sel_pc_in = v.sel_pc;
    alu_sel_imm_in = v.sel_imm; branch_in = v.br; branch_cond_in = v.cond;
    jump_in = v.jmp; jalr_in = v.jalr; load_in = v.ld; store_in = v.st;
    rd_address_in = v.rd;
    rs1_address_in = 5'd1; rs2_address_in = 5'd2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_result", alu_result_out, 32'h0);
    chk("rst_sdata", store_data_out, 32'h0);
    chk("rst_rd", {27'h0, rd_address_out}, 32'h0);
    chk("rst_ldst", {30'h0, load_out, store_out}, 32'h0);
    chk("rst_taken", {31'h0, branch_taken_out}, 32'h0);
    chk("rst_target", branch_target_out, RV);
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] m_res, m_tgt;
    logic m_tk;
    // expected pipeline-register state for the random phase
    logic e_valid, e_taken, e_ld, e_st;
    logic [31:0] e_res, e_sd, e_tgt;
    logic [4:0] e_rd;
    vec_t rv;
    logic s, inv;

    //              v pc            rs1           rs2           imm           fn   sp   si   br   cnd  j    jr   ld   st   rd    tk   result        target
    vecs[0]  = mk(1, 32'h0,        32'd7,        32'd5,        32'h0,        3'd1,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd1, 1'b0,32'd2,        32'h0);
    vecs[1]  = mk(1, 32'h0,        32'h8000_0000,32'h0,        32'd4,        3'd3,1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd2, 1'b0,32'hF800_0000,32'h4);
    vecs[2]  = mk(1, 32'h0,        32'h8000_0000,32'h0,        32'd4,        3'd2,1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0800_0000,32'h4);
    vecs[3]  = mk(1, 32'h100,      32'hFFFF_FFFF,32'd1,        32'h20,       3'd0,1'b0,1'b0,1'b1,3'd4,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,32'h0,        32'h120);
    vecs[4]  = mk(1, 32'h100,      32'hFFFF_FFFF,32'd1,        32'h20,       3'd0,1'b0,1'b0,1'b1,3'd6,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,32'h0,        32'h120);
    vecs[5]  = mk(1, 32'h200,      32'h1001,     32'h0,        32'd4,        3'd0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b1,1'b0,1'b0,5'd1, 1'b1,32'h204,      32'h1004);
    vecs[6]  = mk(1, 32'hFFFF_FFFC,32'h0,        32'h0,        32'd8,        3'd0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,5'd3, 1'b1,32'h0,        32'h4);
    vecs[7]  = mk(1, 32'h40,       32'd5,        32'd5,        32'hFFFF_FFF8,3'd0,1'b0,1'b0,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,32'd10,       32'h38);
    vecs[8]  = mk(1, 32'h0,        32'd1,        32'd2,        32'h0,        3'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,32'd3,        32'h0);
    vecs[9]  = mk(1, 32'h1000,     32'h0,        32'h0,        32'h5000,     3'd0,1'b1,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd4, 1'b0,32'h6000,     32'h6000);
    vecs[10] = mk(0, 32'h0,        32'h0,        32'h0,        32'h0,        3'd0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b1,1'b0,5'd5, 1'b0,32'h4,        32'h0);
    vecs[11] = mk(1, 32'h0,        32'd1,        32'd33,       32'h0,        3'd4,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd6, 1'b0,32'd2,        32'h0);
    vecs[12] = mk(1, 32'h0,        32'h1000,     32'h0,        32'd3,        3'd0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b1,1'b0,1'b0,5'd7, 1'b1,32'h4,        32'h1002);
    vecs[13] = mk(1, 32'h0,        32'h100,      32'hDEAD_BEEF,32'd8,        3'd0,1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,1'b1,5'd0, 1'b0,32'h108,      32'h8);
    vecs[14] = mk(1, 32'h10,       32'hFFFF_FFFB,32'hFFFF_FFFB,32'h10,       3'd0,1'b0,1'b0,1'b1,3'd5,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,32'hFFFF_FFF6,32'h20);

    // Reset state.
    step; step;
    chk_reset;
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      step;
      chk($sformatf("v%0d_valid", i), {31'h0, valid_out}, {31'h0, vecs[i].valid});
      chk($sformatf("v%0d_taken", i), {31'h0, branch_taken_out}, {31'h0, vecs[i].e_taken});
      chk($sformatf("v%0d_ldst", i), {30'h0, load_out, store_out},
          {30'h0, vecs[i].valid & vecs[i].ld, vecs[i].valid & vecs[i].st});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_result", i), alu_result_out, vecs[i].e_result);
        chk($sformatf("v%0d_target", i), branch_target_out, vecs[i].e_target);
        chk($sformatf("v%0d_sdata", i), store_data_out, vecs[i].rs2);
        chk($sformatf("v%0d_rd", i), {27'h0, rd_address_out}, {27'h0, vecs[i].rd});
      end
    end

    // Stall together with invalidate squashes a taken branch.
    drive(vecs[5]);
    step;
    drive(vecs[7]);
    stall = 1'b1; invalidate = 1'b1;
    step;
    chk("inv_valid", {31'h0, valid_out}, 32'h0);
    chk("inv_taken", {31'h0, branch_taken_out}, 32'h0);
    stall = 1'b0; invalidate = 1'b0;
    drive(vecs[0]);
    step;
    // A stall alone holds every output for 3 cycles while the inputs change.
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(vecs[6 + c]);
      step;
      chk($sformatf("stall%0d_valid", c), {31'h0, valid_out}, 32'h1);
      chk($sformatf("stall%0d_result", c), alu_result_out, 32'd2);
      chk($sformatf("stall%0d_taken", c), {31'h0, branch_taken_out}, 32'h0);
      chk($sformatf("stall%0d_rd", c), {27'h0, rd_address_out}, 32'd1);
      chk($sformatf("stall%0d_sdata", c), store_data_out, 32'd5);
    end
    stall = 1'b0;

`ifdef EXECUTE_FORWARD_EN
    // The memory-stage forward wins over writeback.
    drive(mk(1, 32'h0, 32'd99, 32'd1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
             1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0));
    rs1_address_in = 5'd3; rs2_address_in = 5'd0;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'd10;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'd20;
    step;
    chk("fwd_mem", alu_result_out, 32'd11);
    rs1_address_in = 5'd0; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0; rs1_data_in = 32'd50;
    step;
    chk("fwd_x0", alu_result_out, 32'd51);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
`endif

    // Reset mid-operation takes effect immediately, without waiting for a clock edge.
    drive(mk(1, 32'h0, 32'd3, 32'd4, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
             1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 32'h0, 32'h0));
    step;
    chk("pre_rst_result", alu_result_out, 32'd7);
    #2 reset = 1'b1;
    #1 chk_reset;
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the model.
    e_valid = 1'b0; e_taken = 1'b0; e_ld = 1'b0; e_st = 1'b0;
    e_res = 32'h0; e_sd = 32'h0; e_tgt = RV; e_rd = 5'd0;
    for (int n = 0; n < 400; n++) begin
      rv.valid = ($urandom_range(0, 7) != 0);
      rv.pc = $urandom & 32'hFFFF_FFFC;
      rv.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rv.rs2 = ($urandom_range(0, 3) == 0) ? rv.rs1 : $urandom;
      rv.imm = $urandom;
      rv.fn = 3'($urandom_range(0, 7));
      rv.sel_pc = ($urandom_range(0, 3) == 0);
      rv.sel_imm = $urandom_range(0, 1) == 1;
      rv.br = $urandom_range(0, 1) == 1;
      rv.cond = 3'($urandom_range(0, 7));
      rv.jmp = ($urandom_range(0, 4) == 0);
      rv.jalr = rv.jmp & ($urandom_range(0, 1) == 1);
      rv.ld = $urandom_range(0, 1) == 1;
      rv.st = $urandom_range(0, 1) == 1;
      rv.rd = 5'($urandom_range(0, 31));
      s = ($urandom_range(0, 7) == 0);
      inv = ($urandom_range(0, 9) == 0);
      drive(rv);
      stall = s; invalidate = inv;
      model(rv, m_res, m_tk, m_tgt);
      if (inv) begin
        e_valid = 1'b0; e_taken = 1'b0; e_ld = 1'b0; e_st = 1'b0;
      end else if (!s) begin
        e_valid = rv.valid; e_taken = m_tk; e_ld = rv.valid & rv.ld;
        e_st = rv.valid & rv.st; e_res = m_res; e_sd = rv.rs2; e_tgt = m_tgt; e_rd = rv.rd;
      end
      step;
      chk("rnd_valid", {31'h0, valid_out}, {31'h0, e_valid});
      chk("rnd_taken", {31'h0, branch_taken_out}, {31'h0, e_taken});
      chk("rnd_ldst", {30'h0, load_out, store_out}, {30'h0, e_ld, e_st});
      if (e_valid) begin
        chk("rnd_result", alu_result_out, e_res);
        chk("rnd_target", branch_target_out, e_tgt);
        chk("rnd_sdata", store_data_out, e_sd);
        chk("rnd_rd", {27'h0, rd_address_out}, {27'h0, e_rd});
      end
    end
    stall = 1'b0; invalidate = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
